// File: rtl/divider_host_link_if.sv
// Host/command/response signal bundle for divider_host_link.
// master = host plus divider-controller side, slave = divider_host_link itself.
interface divider_host_link_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_mode;
  logic [31:0] req_num;
  logic [31:0] req_den;
  logic        write;
  logic [95:0] out_data;
  logic        write_in;
  logic [95:0] write_out;
  logic        rsp_valid;
  logic [2:0]  rsp_status;
  logic [31:0] rsp_quot;
  logic [31:0] rsp_rem;

  modport master (
    output req_valid, req_mode, req_num, req_den, write_in, write_out,
    input  req_ready, write, out_data, rsp_valid, rsp_status, rsp_quot, rsp_rem
  );

  modport slave (
    input  req_valid, req_mode, req_num, req_den, write_in, write_out,
    output req_ready, write, out_data, rsp_valid, rsp_status, rsp_quot, rsp_rem
  );
endinterface

// File: rtl/divider_host_link.sv
// Initiator side of the divider command/response link with validation, tag check and timeout.
// Optional zero-denominator rejection is enabled by defining DIVIDER_ZERO_CHECK_EN.
module divider_host_link #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic           divider_clk,
  input logic           reset,
  divider_host_link_if.slave link
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    RS_OK       = 3'd0,
    RS_BAD_MODE = 3'd1,
    RS_TIMEOUT  = 3'd2,
    RS_BAD_TAG  = 3'd3,
    RS_DIV_ZERO = 3'd4
  } status_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  mode_q, mode_d;
  logic [31:0] num_q, num_d;
  logic [31:0] den_q, den_d;
  status_t     status_q, status_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;

  logic        mode_legal;
  logic [31:0] num_masked;
  logic [31:0] den_masked;
  logic        tag_ok;

  function automatic logic [31:0] width_mask(input logic [7:0] mode);
    logic [31:0] m;
    case (mode)
      8'd1:    m = 32'h0000_00FF;
      8'd2:    m = 32'h0000_FFFF;
      8'd3:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  assign mode_legal = (link.req_mode >= 8'd1) && (link.req_mode <= 8'd4);
  assign num_masked = link.req_num & width_mask(link.req_mode);
  assign den_masked = link.req_den & width_mask(link.req_mode);
  assign tag_ok     = (link.write_out[95:80] == 16'h000A) &&
                      (link.write_out[47:32] == 16'h000B);

  always_ff @(posedge divider_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      num_q    <= '0;
      den_q    <= '0;
      status_q <= RS_OK;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      num_q    <= num_d;
      den_q    <= den_d;
      status_q <= status_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    num_d    = num_q;
    den_d    = den_q;
    status_d = status_q;
    quot_d   = quot_q;
    rem_d    = rem_q;

    case (state_q)
      S_IDLE: begin
        if (link.req_valid) begin
          mode_d = link.req_mode;
          num_d  = num_masked;
          den_d  = den_masked;
          if (!mode_legal) begin
            state_d  = S_DONE;
            status_d = RS_BAD_MODE;
            quot_d   = '0;
            rem_d    = '0;
`ifdef DIVIDER_ZERO_CHECK_EN
          end else if (den_masked == '0) begin
            state_d  = S_DONE;
            status_d = RS_DIV_ZERO;
            quot_d   = '0;
            rem_d    = '0;
`endif
          end else begin
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      // Timeout fires on the edge where the incremented count reaches
      // TIMEOUT_CYCLES-1, so DONE lands TIMEOUT_CYCLES cycles after SEND.
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (link.write_in) begin
          state_d = S_CAPT;
        end else if (cnt_d == TO_LAST) begin
          state_d  = S_DONE;
          status_d = RS_TIMEOUT;
          quot_d   = '0;
          rem_d    = '0;
        end
      end

      S_CAPT: begin
        state_d = S_DONE;
        if (tag_ok) begin
          status_d = RS_OK;
          quot_d   = link.write_out[79:48];
          rem_d    = link.write_out[31:0];
        end else begin
          status_d = RS_BAD_TAG;
          quot_d   = '0;
          rem_d    = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are gated by reset so they drop in the cycle reset is raised.
  assign link.req_ready  = (state_q == S_IDLE) && !reset;
  assign link.write      = (state_q == S_SEND) && !reset;
  assign link.out_data   = link.write ? {mode_q, 8'h00, den_q, mode_q, 8'h01, num_q} : '0;
  assign link.rsp_valid  = (state_q == S_DONE) && !reset;
  assign link.rsp_status = status_q;
  assign link.rsp_quot   = quot_q;
  assign link.rsp_rem    = rem_q;

endmodule

// File: tb/tb_divider_host_link.sv
// Scoreboard bench for divider_host_link: stimulus pushes expected commands/responses,
// a negedge monitor pops and compares them, including the cycle they appear on.
module tb_divider_host_link;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    int          inst;
    logic [2:0]  st;
    logic [31:0] q;
    logic [31:0] r;
    int          at;
  } rsp_t;

  typedef struct {
    int          inst;
    logic [95:0] d;
    int          at;
  } cmd_t;

  rsp_t rsp_q[$];
  cmd_t cmd_q[$];

  divider_host_link_if lk ();
  divider_host_link_if lk8 ();

  divider_host_link u_dut (
    .divider_clk (clk),
    .reset       (reset),
    .link        (lk)
  );

  divider_host_link #(.TIMEOUT_CYCLES(8)) u_dut8 (
    .divider_clk (clk),
    .reset       (reset),
    .link        (lk8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rsp(input int inst, input logic v, input logic [2:0] st,
                         input logic [31:0] q, input logic [31:0] r);
    rsp_t e;
    if (v !== 1'b1) return;
    if (rsp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_rsp: inst %0d rsp_valid=1 required 0 (cycle %0d)", inst, cyc);
      return;
    end
    e = rsp_q.pop_front();
    check("rsp_inst", inst, e.inst);
    check("rsp_status", st, e.st);
    check("rsp_quot", q, e.q);
    check("rsp_rem", r, e.r);
    check("rsp_cycle", cyc, e.at);
  endtask

  task automatic chk_cmd(input int inst, input logic w, input logic [95:0] d);
    cmd_t e;
    if (w !== 1'b1) return;
    if (cmd_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_write: inst %0d write=1 data 0x%0h required no write (cycle %0d)",
               inst, d, cyc);
      return;
    end
    e = cmd_q.pop_front();
    check("cmd_inst", inst, e.inst);
    check("cmd_data", d, e.d);
    check("cmd_cycle", cyc, e.at);
  endtask

  always @(negedge clk) begin
    chk_cmd(0, lk.write, lk.out_data);
    chk_cmd(1, lk8.write, lk8.out_data);
    chk_rsp(0, lk.rsp_valid, lk.rsp_status, lk.rsp_quot, lk.rsp_rem);
    chk_rsp(1, lk8.rsp_valid, lk8.rsp_status, lk8.rsp_quot, lk8.rsp_rem);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_of(input int inst);
    return (inst == 0) ? lk.req_ready : lk8.req_ready;
  endfunction

  task automatic drive_req(input int inst, input logic v, input logic [7:0] m,
                           input logic [31:0] n, input logic [31:0] d);
    if (inst == 0) begin
      lk.req_valid = v; lk.req_mode = m; lk.req_num = n; lk.req_den = d;
    end else begin
      lk8.req_valid = v; lk8.req_mode = m; lk8.req_num = n; lk8.req_den = d;
    end
  endtask

  task automatic drive_rsp(input int inst, input logic v, input logic [95:0] w);
    if (inst == 0) begin
      lk.write_in = v; lk.write_out = w;
    end else begin
      lk8.write_in = v; lk8.write_out = w;
    end
  endtask

  task automatic issue(input int inst, input logic [7:0] m, input logic [31:0] n,
                       input logic [31:0] d, output int acc);
    check("req_ready_before_req", ready_of(inst), 1'b1);
    drive_req(inst, 1'b1, m, n, d);
    acc = cyc + 1;
    tick();
    drive_req(inst, 1'b0, '0, '0, '0);
  endtask

  // Upper half valid first with junk in the lower half, full word on the second cycle.
  task automatic respond(input int inst, input logic [47:0] hi, input logic [47:0] lo,
                         output int first);
    drive_rsp(inst, 1'b1, {hi, 48'h5A5A_5A5A_5A5A});
    first = cyc;
    tick();
    drive_rsp(inst, 1'b1, {hi, lo});
    tick();
    drive_rsp(inst, 1'b0, '0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (rsp_q.size() + cmd_q.size()) != 0; i++) tick();
    check("outstanding_expectations", rsp_q.size() + cmd_q.size(), 0);
    rsp_q.delete();
    cmd_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int c;

    reset = 1'b1;
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    drive_rsp(0, 1'b0, '0);
    drive_rsp(1, 1'b0, '0);
    repeat (3) tick();
    check("reset_req_ready", lk.req_ready, 1'b0);
    check("reset_write", lk.write, 1'b0);
    check("reset_rsp_valid", lk.rsp_valid, 1'b0);
    reset = 1'b0;
    tick();
    check("post_reset_req_ready", lk.req_ready, 1'b1);
    check("post_reset_req_ready8", lk8.req_ready, 1'b1);
    check("post_reset_status", lk.rsp_status, 3'd0);
    check("post_reset_quot", lk.rsp_quot, 32'h0);
    check("post_reset_out_data", lk.out_data, 96'h0);

    // Mode 1: operands masked to 8 bits
    issue(0, 8'd1, 32'h0000_01FF, 32'h0000_0003, acc);
    cmd_q.push_back('{0, 96'h01_00_00000003_01_01_000000FF, acc});
    repeat (10) tick();
    respond(0, {16'h000A, 32'h0000_0055}, {16'h000B, 32'h0000_0000}, c);
    rsp_q.push_back('{0, 3'd0, 32'h0000_0055, 32'h0, c + 2});
    drain(20);
    check("held_quot", lk.rsp_quot, 32'h0000_0055);
    check("held_status", lk.rsp_status, 3'd0);

    // Mode 4 with a duplicate response that must be ignored
    issue(0, 8'd4, 32'hFFFF_FFFF, 32'h0000_0010, acc);
    cmd_q.push_back('{0, 96'h04_00_00000010_04_01_FFFFFFFF, acc});
    repeat (3) tick();
    respond(0, {16'h000A, 32'h0FFF_FFFF}, {16'h000B, 32'h0000_000F}, c);
    rsp_q.push_back('{0, 3'd0, 32'h0FFF_FFFF, 32'h0000_000F, c + 2});
    tick();
    respond(0, {16'h000A, 32'h0FFF_FFFF}, {16'h000B, 32'h0000_000F}, c);
    repeat (4) tick();
    drain(10);
    check("ready_after_duplicate", lk.req_ready, 1'b1);

    // Reset during WAIT aborts without a response and clears held results
    issue(0, 8'd3, 32'hAB12_3456, 32'h0100_0010, acc);
    cmd_q.push_back('{0, 96'h03_00_00000010_03_01_00123456, acc});
    repeat (4) tick();
    reset = 1'b1;
    check("reset_write_drops", lk.write, 1'b0);
    tick();
    check("wait_reset_req_ready", lk.req_ready, 1'b0);
    check("wait_reset_rsp_valid", lk.rsp_valid, 1'b0);
    check("wait_reset_out_data", lk.out_data, 96'h0);
    check("wait_reset_status", lk.rsp_status, 3'd0);
    check("wait_reset_quot", lk.rsp_quot, 32'h0);
    check("wait_reset_rem", lk.rsp_rem, 32'h0);
    tick();
    reset = 1'b0;
    repeat (12) tick();
    check("ready_after_abort", lk.req_ready, 1'b1);
    issue(0, 8'd3, 32'hAB12_3456, 32'h0100_0010, acc);
    cmd_q.push_back('{0, 96'h03_00_00000010_03_01_00123456, acc});
    repeat (5) tick();
    respond(0, {16'h000A, 32'h0001_2345}, {16'h000B, 32'h0000_0006}, c);
    rsp_q.push_back('{0, 3'd0, 32'h0001_2345, 32'h0000_0006, c + 2});
    drain(20);

    // Illegal modes: no write, response on the cycle after accept
    issue(0, 8'd5, 32'h1234_5678, 32'h0000_0002, acc);
    rsp_q.push_back('{0, 3'd1, 32'h0, 32'h0, acc});
    drain(10);
    issue(0, 8'd0, 32'h1234_5678, 32'h0000_0002, acc);
    rsp_q.push_back('{0, 3'd1, 32'h0, 32'h0, acc});
    drain(10);

    // Timeout on the 8-cycle instance, then a late response is ignored
    issue(1, 8'd2, 32'h0000_1234, 32'h0000_0011, acc);
    cmd_q.push_back('{1, 96'h02_00_00000011_02_01_00001234, acc});
    rsp_q.push_back('{1, 3'd2, 32'h0, 32'h0, acc + 8});
    drain(30);
    respond(1, {16'h000A, 32'h0000_0111}, {16'h000B, 32'h0000_0001}, c);
    repeat (4) tick();
    drain(5);
    check("ready8_after_late_rsp", lk8.req_ready, 1'b1);

    // Wrong lower tag
    issue(0, 8'd2, 32'h0001_2345, 32'h0000_0007, acc);
    cmd_q.push_back('{0, 96'h02_00_00000007_02_01_00002345, acc});
    repeat (2) tick();
    respond(0, {16'h000A, 32'h0000_1111}, {16'h000C, 32'h0000_2222}, c);
    rsp_q.push_back('{0, 3'd3, 32'h0, 32'h0, c + 2});
    drain(20);

    // Denominator that masks to zero
    issue(0, 8'd1, 32'h0000_0042, 32'h0000_0100, acc);
`ifdef DIVIDER_ZERO_CHECK_EN
    rsp_q.push_back('{0, 3'd4, 32'h0, 32'h0, acc});
`else
    cmd_q.push_back('{0, 96'h01_00_00000000_01_01_00000042, acc});
    repeat (2) tick();
    respond(0, {16'h000A, 32'h0000_0000}, {16'h000B, 32'h0000_0042}, c);
    rsp_q.push_back('{0, 3'd0, 32'h0, 32'h0000_0042, c + 2});
`endif
    drain(20);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
